// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the gpio pattern sequencer: register map, FSM states, bus payload.
package gpio_seq_pkg;

  // gpio peripheral register offsets
  localparam logic [31:0] GPIO_REG_DATA = 32'h0000_0000;

  // Sequencer register offsets (decoded on addr[4:0])
  localparam logic [4:0] SEQ_CTRL   = 5'h00;
  localparam logic [4:0] SEQ_STATUS = 5'h04;
  localparam logic [4:0] SEQ_LEN    = 5'h08;
  localparam logic [4:0] SEQ_HOLD   = 5'h0C;
  localparam logic [4:0] SEQ_PAT    = 5'h10;
  localparam logic [4:0] SEQ_PTR    = 5'h14;

  // CTRL bit positions
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_LOOP  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // One gpio bus request
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
  } gpio_req_t;

endpackage

// File: rtl/gpio_seq_mem.sv
// Pattern storage: single write port, asynchronous read, contents not reset.
module gpio_seq_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_seq.sv
// gpio pattern sequencer with fixed-priority arbitration against host gpio accesses.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  input  logic [31:0] host_gpio_addr_i,
  input  logic [31:0] host_gpio_wdata_i,
  input  logic        host_gpio_we_i,
  input  logic        host_gpio_re_i,
  output logic        host_gpio_ready_o,
  output logic [31:0] host_gpio_rdata_o,
  output logic [31:0] gpio_addr_o,
  output logic [31:0] gpio_wdata_o,
  output logic        gpio_we_o,
  output logic        gpio_re_o,
  input  logic [31:0] gpio_rdata_i,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, wptr_q;
  logic [AW:0]       len_q;
  logic [HOLD_W-1:0] hold_q, cnt_q;
  logic              done_q, loop_q;
  logic [WIDTH-1:0]  mem_rdata;

  logic busy, ctrl_wr, start_req, stop_req, cfg_wr, mem_we, last_step;
  logic start_acc, step_done, end_run;
  gpio_req_t host_req, bus_req;

  // Only addr[4:0] is decoded
  logic unused_addr;
  assign unused_addr = ^addr_i[31:5];

  assign busy      = (state_q != ST_IDLE);
  assign ctrl_wr   = we_i && (addr_i[4:0] == SEQ_CTRL);
  assign start_req = ctrl_wr && wdata_i[CTRL_START];
  assign stop_req  = ctrl_wr && wdata_i[CTRL_STOP];
  assign cfg_wr    = we_i && !busy;
  assign mem_we    = cfg_wr && (addr_i[4:0] == SEQ_PAT);
  assign last_step = ((AW+1)'(idx_q) + (AW+1)'(1)) >= len_q;

  gpio_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (wdata_i[WIDTH-1:0]),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and step control
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    step_done = 1'b0;
    end_run   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req && !stop_req && (len_q != '0)) begin
          start_acc = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (hold_q == '0) step_done = 1'b1;
        else              state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) step_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (step_done) begin
      if (!last_step || loop_q) begin
        state_d = ST_WRITE;
      end else begin
        state_d = ST_IDLE;
        end_run = 1'b1;
      end
    end
    // Stop overrides everything and never sets done
    if (stop_req) begin
      state_d = ST_IDLE;
      end_run = 1'b0;
    end
  end

  // Datapath: config registers, step index, hold counter, status
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      wptr_q <= '0;
      len_q  <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      loop_q <= 1'b0;
    end else begin
      if (ctrl_wr) loop_q <= wdata_i[CTRL_LOOP];
      if (start_acc) begin
        done_q <= 1'b0;
        idx_q  <= '0;
      end
      if (end_run) done_q <= 1'b1;
      if (state_q == ST_WRITE && hold_q != '0) cnt_q <= hold_q - HOLD_W'(1);
      if (state_q == ST_HOLD && cnt_q != '0)   cnt_q <= cnt_q - HOLD_W'(1);
      if (step_done) idx_q <= last_step ? '0 : idx_q + AW'(1);
      if (cfg_wr) begin
        case (addr_i[4:0])
          SEQ_LEN:  len_q  <= (wdata_i > 32'(DEPTH)) ? (AW+1)'(DEPTH) : wdata_i[AW:0];
          SEQ_HOLD: hold_q <= wdata_i[HOLD_W-1:0];
          SEQ_PAT:  wptr_q <= wptr_q + AW'(1);
          SEQ_PTR:  wptr_q <= wdata_i[AW-1:0];
          default: ;
        endcase
      end
    end
  end

  // Register read mux
  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      case (addr_i[4:0])
        SEQ_STATUS: rdata_o = 32'({done_q, busy});
        SEQ_LEN:    rdata_o = 32'(len_q);
        SEQ_HOLD:   rdata_o = 32'(hold_q);
        SEQ_PTR:    rdata_o = 32'(wptr_q);
        default:    rdata_o = '0;
      endcase
    end
  end

  // Arbiter: sequencer owns the bus in WRITE, host passes through otherwise
  always_comb begin
    host_req = '{addr: host_gpio_addr_i, wdata: host_gpio_wdata_i,
                 we: host_gpio_we_i, re: host_gpio_re_i};
    bus_req  = host_req;
    if (state_q == ST_WRITE) begin
      bus_req = '{addr: GPIO_REG_DATA, wdata: 32'(mem_rdata), we: 1'b1, re: 1'b0};
    end
  end

  assign host_gpio_ready_o = (state_q != ST_WRITE);
  assign host_gpio_rdata_o = host_gpio_ready_o ? gpio_rdata_i : '0;
  assign gpio_addr_o       = bus_req.addr;
  assign gpio_wdata_o      = bus_req.wdata;
  assign gpio_we_o         = bus_req.we;
  assign gpio_re_o         = bus_req.re;
  assign busy_o            = busy;

endmodule
